// File: rtl/gf32_mul_arbiter_pkg.sv
// Shared definitions for the GF(2^32) multiplier arbiter.
//   state_t        : 2-bit FSM encoding (S_IDLE, S_ISSUE, S_WAIT, S_RELEASE)
//   DEFAULT_N_REQ  : default number of requesters
//   GF32_W         : field element width in bits
package sdith_arb_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int GF32_W        = 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/gf32_mul_arbiter_if.sv
// Requester/multiplier bundle for gf32_mul_arbiter.
//   slave  : arbiter view (requests and multiplier results in; grants, pulses,
//            operands and result out)
//   master : requester/multiplier/testbench view (directions mirrored)
// Operand lanes are packed 32 bits per requester, requester r at [32r+31:32r].
interface gf32_mul_arbiter_if
    import sdith_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ
);
    logic [N_REQ-1:0]        i_req;
    logic [GF32_W*N_REQ-1:0] i_x;
    logic [GF32_W*N_REQ-1:0] i_y;
    logic [N_REQ-1:0]        o_grant;
    logic [N_REQ-1:0]        o_done;
    logic [GF32_W-1:0]       o_result;
    logic                    o_start_mul32;
    logic [GF32_W-1:0]       o_x_mul32;
    logic [GF32_W-1:0]       o_y_mul32;
    logic [GF32_W-1:0]       i_o_mul32;
    logic                    i_done_mul32;
    logic                    o_busy;

    modport slave (
        input  i_req, i_x, i_y, i_o_mul32, i_done_mul32,
        output o_grant, o_done, o_result, o_start_mul32,
               o_x_mul32, o_y_mul32, o_busy
    );

    modport master (
        output i_req, i_x, i_y, i_o_mul32, i_done_mul32,
        input  o_grant, o_done, o_result, o_start_mul32,
               o_x_mul32, o_y_mul32, o_busy
    );
endinterface

// File: rtl/gf32_mul_arbiter_rr_priority_picker.sv
// Combinational rotating-priority picker.
//   i_req   : request vector
//   i_ptr   : index where the search starts (tie to 0 for fixed priority)
//   o_grant : one-hot winner, all-zero when no request
//   o_idx   : binary index of the winner
//   o_valid : at least one request present
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        o_grant  = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // i_ptr is always < N_REQ, so one wrap subtraction is enough.
            cand = int'(i_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!o_valid && i_req[cand_idx]) begin
                o_valid           = 1'b1;
                o_grant[cand_idx] = 1'b1;
                o_idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/gf32_mul_arbiter.sv
// Shares one GF(2^32) multiplier between N_REQ requesters.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst_n : synchronous active-low reset
//   arb     : gf32_mul_arbiter_if.slave (requests, operands, grants, done
//             pulses, shared result, multiplier start/operands/product)
// Optional feature: define GF32_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority, lowest index wins, and no pointer register exists.
//
// Timing: a request seen in S_IDLE moves to S_ISSUE; the start pulse is
// registered out of S_ISSUE, so it appears 2 cycles after i_req rises.
// o_done and o_result are registered on i_done_mul32, so they appear 1 cycle
// after the multiplier's done.
module gf32_mul_arbiter
    import sdith_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    gf32_mul_arbiter_if.slave arb
);

    state_t            state_reg, state_next;
    logic [N_REQ-1:0]  grant_reg, grant_next;
    logic [N_REQ-1:0]  done_reg, done_next;
    logic [GF32_W-1:0] result_reg, result_next;
    logic [GF32_W-1:0] x_reg, x_next;
    logic [GF32_W-1:0] y_reg, y_next;
    logic              start_reg, start_next;

    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_ptr;

    logic [GF32_W-1:0] x_lane [N_REQ];
    logic [GF32_W-1:0] y_lane [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
        assign x_lane[gi] = arb.i_x[GF32_W*gi +: GF32_W];
        assign y_lane[gi] = arb.i_y[GF32_W*gi +: GF32_W];
    end

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (arb.i_req),
        .i_ptr   (pick_ptr),
        .o_grant (pick_grant),
        .o_idx   (pick_idx),
        .o_valid (pick_valid)
    );

`ifdef GF32_ARB_ROUND_ROBIN_EN
    // Pointer holds the index where the next search begins (last winner + 1).
    logic [IDX_W-1:0] ptr_reg, ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (state_reg == S_IDLE && pick_valid) begin
            ptr_next = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign pick_ptr = ptr_reg;
`else
    assign pick_ptr = '0;
`endif

    // Next-state and next-output logic. Operands are captured only on the
    // S_IDLE -> S_ISSUE transition; grant is held untouched until S_RELEASE
    // exits, so an owner dropping its request cannot disturb the operation.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        result_next = result_reg;
        start_next  = 1'b0;
        done_next   = '0;
        case (state_reg)
            S_IDLE: begin
                if (pick_valid) begin
                    state_next = S_ISSUE;
                    grant_next = pick_grant;
                    x_next     = x_lane[pick_idx];
                    y_next     = y_lane[pick_idx];
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
                start_next = 1'b1;
            end
            S_WAIT: begin
                // Multiplier done is only honoured here; elsewhere it is noise.
                if (arb.i_done_mul32) begin
                    state_next  = S_RELEASE;
                    result_next = arb.i_o_mul32;
                    done_next   = grant_reg;
                end
            end
            S_RELEASE: begin
                state_next = S_IDLE;
                grant_next = '0;
            end
            default: begin
                state_next = S_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg  <= S_IDLE;
            grant_reg  <= '0;
            done_reg   <= '0;
            result_reg <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            start_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            done_reg   <= done_next;
            result_reg <= result_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            start_reg  <= start_next;
        end
    end

    assign arb.o_grant       = grant_reg;
    assign arb.o_done        = done_reg;
    assign arb.o_result      = result_reg;
    assign arb.o_start_mul32 = start_reg;
    assign arb.o_x_mul32     = x_reg;
    assign arb.o_y_mul32     = y_reg;
    assign arb.o_busy        = (state_reg != S_IDLE);

endmodule
